// File: rtl/clock_pkg.sv
// Shared definitions for the two-digit entry merger.
//   fig_state_e   : FSM state encoding (idle = no digit held, tens = tens digit held)
//   DefaultMaxVal : default upper bound for a merged two-digit value
package clock_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StTens = 1'b1
  } fig_state_e;

  localparam int unsigned DefaultMaxVal = 59;

endpackage

// File: rtl/fig_digit_check.sv
// Combinational digit-range and sum-limit check for the two-digit merger.
// Forms tens*10+ones with shifts and adds only, and flags whether both digits
// are decimal and the sum does not exceed MAX_VAL. A tens-only check is done by
// presenting ones_i = 0.
//   tens_i : tens digit candidate
//   ones_i : ones digit candidate
//   sum_o  : tens*10 + ones, 7 bits
//   ok_o   : both digits <= 9 and sum_o <= MAX_VAL
module fig_digit_check #(
  parameter int unsigned MAX_VAL = 59
) (
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  output logic [6:0] sum_o,
  output logic       ok_o
);

  localparam logic [6:0] MaxVal7 = 7'(MAX_VAL);

  logic [6:0] tens7;
  logic [6:0] ones7;

  assign tens7 = {3'b000, tens_i};
  assign ones7 = {3'b000, ones_i};

  // A non-decimal tens digit can wrap the 7-bit sum, but it is rejected by the range
  // test regardless of the sum.
  assign sum_o = (tens7 << 3) + (tens7 << 1) + ones7;

  assign ok_o = (tens_i <= 4'd9) && (ones_i <= 4'd9) && (sum_o <= MaxVal7);

endmodule

// File: rtl/double_fig_merge.sv
// Merges two successive decimal digit strobes (tens, then ones) into one value.
// Optional feature macro: DOUBLE_FIG_MERGE_TIMEOUT_EN -- when defined, a partial
// entry held longer than TIMEOUT_CYC cycles is abandoned with an error pulse.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_digit      : digit value, sampled when i_digit_vld = 1
//   i_digit_vld  : one-cycle digit strobe
//   i_clear      : abandon any partial entry (wins over a coincident strobe)
//   o_double_fig : last successfully merged value
//   o_vld        : one-cycle pulse, o_double_fig updated
//   o_err        : one-cycle pulse, entry rejected (or timed out)
//   o_busy       : tens digit held, ones digit awaited
module double_fig_merge
  import clock_pkg::*;
#(
  parameter int unsigned MAX_VAL     = DefaultMaxVal,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_digit,
  input  logic       i_digit_vld,
  input  logic       i_clear,
  output logic [6:0] o_double_fig,
  output logic       o_vld,
  output logic       o_err,
  output logic       o_busy
);

  if (MAX_VAL < 9 || MAX_VAL > 99 || TIMEOUT_CYC < 2) begin : gen_bad_param
    $error("double_fig_merge: MAX_VAL must be 9..99 and TIMEOUT_CYC at least 2");
  end

  fig_state_e state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [6:0] fig_q, fig_d;
  logic       vld_q, vld_d;
  logic       err_q, err_d;
  // Low for the first edge after reset release so a strobe racing the release is dropped.
  logic       rdy_q;

  logic       strobe;
  logic [3:0] chk_tens;
  logic [3:0] chk_ones;
  logic [6:0] chk_sum;
  logic       chk_ok;
  logic       timeout;

  assign strobe = i_digit_vld & rdy_q;

  // One checker serves both states: in idle the incoming digit is the tens candidate.
  assign chk_tens = (state_q == StTens) ? tens_q : i_digit;
  assign chk_ones = (state_q == StTens) ? i_digit : 4'd0;

  fig_digit_check #(
    .MAX_VAL(MAX_VAL)
  ) u_check (
    .tens_i(chk_tens),
    .ones_i(chk_ones),
    .sum_o (chk_sum),
    .ok_o  (chk_ok)
  );

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    fig_d   = fig_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    if (i_clear) begin
      state_d = StIdle;
    end else if (strobe) begin
      unique case (state_q)
        StIdle: begin
          if (chk_ok) begin
            tens_d  = i_digit;
            state_d = StTens;
          end else begin
            err_d = 1'b1;
          end
        end
        StTens: begin
          if (chk_ok) begin
            fig_d = chk_sum;
            vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end
  end

`ifdef DOUBLE_FIG_MERGE_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYC - 1);

  logic [31:0] cnt_q, cnt_d;

  assign timeout = (state_q == StTens) && (cnt_q == TimeoutLast);

  // Counts only while staying in tens; any state entry restarts from zero.
  always_comb begin
    cnt_d = '0;
    if (state_q == StTens && state_d == StTens) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tens_q  <= '0;
      fig_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      fig_q   <= fig_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  assign o_double_fig = fig_q;
  assign o_vld        = vld_q;
  assign o_err        = err_q;
  assign o_busy       = (state_q == StTens);

endmodule

// File: tb/tb_double_fig_merge.sv
// Directed bench for double_fig_merge: a vector table for the main digit stream plus
// hand-written sequences for reset release, partial-entry hold/timeout and async reset.
module tb_double_fig_merge;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_digit;
  logic       i_digit_vld;
  logic       i_clear;
  logic [6:0] o_double_fig;
  logic       o_vld;
  logic       o_err;
  logic       o_busy;

  int n_vec;
  int n_bad;

  double_fig_merge #(
    .MAX_VAL    (59),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_digit     (i_digit),
    .i_digit_vld (i_digit_vld),
    .i_clear     (i_clear),
    .o_double_fig(o_double_fig),
    .o_vld       (o_vld),
    .o_err       (o_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] digit;
    logic       vld;
    logic       clr;
    logic [6:0] fig;
    logic       ovld;
    logic       err;
    logic       busy;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [6:0] fig, input logic ovld,
                       input logic err, input logic busy);
    n_vec++;
    if ({o_double_fig, o_vld, o_err, o_busy} !== {fig, ovld, err, busy}) begin
      n_bad++;
      $display("FAIL %s: got fig=%0d vld=%b err=%b busy=%b, want fig=%0d vld=%b err=%b busy=%b",
               name, o_double_fig, o_vld, o_err, o_busy, fig, ovld, err, busy);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic [3:0] digit, input logic vld, input logic clr);
    @(negedge clk);
    i_digit     = digit;
    i_digit_vld = vld;
    i_clear     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //               digit  vld   clr   fig    vld   err   busy
    vecs[0]  = '{4'd4,  1'b1, 1'b0, 7'd0,  1'b0, 1'b0, 1'b1};
    vecs[1]  = '{4'd7,  1'b1, 1'b0, 7'd47, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'd0,  1'b0, 1'b0, 7'd47, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd6,  1'b1, 1'b0, 7'd47, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'd5,  1'b1, 1'b0, 7'd47, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{4'd9,  1'b1, 1'b0, 7'd59, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'd3,  1'b1, 1'b0, 7'd59, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'd2,  1'b1, 1'b1, 7'd59, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd1,  1'b1, 1'b0, 7'd59, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{4'd5,  1'b1, 1'b0, 7'd15, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'd2,  1'b1, 1'b0, 7'd15, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'hC,  1'b1, 1'b0, 7'd15, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd5,  1'b1, 1'b0, 7'd15, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{4'd0,  1'b1, 1'b0, 7'd50, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'd0,  1'b1, 1'b0, 7'd50, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{4'd9,  1'b1, 1'b0, 7'd9,  1'b1, 1'b0, 1'b0};
    vecs[16] = '{4'hF,  1'b1, 1'b0, 7'd9,  1'b0, 1'b1, 1'b0};
    vecs[17] = '{4'd5,  1'b1, 1'b0, 7'd9,  1'b0, 1'b0, 1'b1};
    vecs[18] = '{4'hA,  1'b1, 1'b0, 7'd9,  1'b0, 1'b1, 1'b0};
    vecs[19] = '{4'd0,  1'b0, 1'b1, 7'd9,  1'b0, 1'b0, 1'b0};
    vecs[20] = '{4'd3,  1'b1, 1'b0, 7'd9,  1'b0, 1'b0, 1'b1};
    vecs[21] = '{4'd0,  1'b0, 1'b0, 7'd9,  1'b0, 1'b0, 1'b1};
    vecs[22] = '{4'd6,  1'b1, 1'b0, 7'd36, 1'b1, 1'b0, 1'b0};

    rst_n       = 1'b0;
    i_digit     = '0;
    i_digit_vld = 1'b0;
    i_clear     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 7'd0, 1'b0, 1'b0, 1'b0);

    // Strobe presented in the same cycle reset is released must be ignored.
    @(negedge clk);
    rst_n       = 1'b1;
    i_digit     = 4'd3;
    i_digit_vld = 1'b1;
    @(posedge clk);
    #1;
    check("strobe_at_reset_release", 7'd0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    check("idle_after_release", 7'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].digit, vecs[i].vld, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].fig, vecs[i].ovld, vecs[i].err, vecs[i].busy);
    end

    // Partial entry held with no further strobes.
    step(4'd3, 1'b1, 1'b0);
    check("hold_enter_tens", 7'd36, 1'b0, 1'b0, 1'b1);
`ifdef DOUBLE_FIG_MERGE_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step(4'd0, 1'b0, 1'b0);
      check($sformatf("timeout_wait%0d", i), 7'd36, 1'b0, 1'b0, 1'b1);
    end
    step(4'd0, 1'b0, 1'b0);
    check("timeout_err", 7'd36, 1'b0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    check("timeout_err_one_cycle", 7'd36, 1'b0, 1'b0, 1'b0);
`else
    repeat (20) step(4'd0, 1'b0, 1'b0);
    check("hold_no_timeout", 7'd36, 1'b0, 1'b0, 1'b1);
    step(4'd1, 1'b1, 1'b0);
    check("hold_then_ones", 7'd31, 1'b1, 1'b0, 1'b0);
`endif

    // Asynchronous reset while a tens digit is held.
    step(4'd4, 1'b1, 1'b0);
    check("pre_reset_tens", (`ifdef DOUBLE_FIG_MERGE_TIMEOUT_EN 7'd36 `else 7'd31 `endif),
          1'b0, 1'b0, 1'b1);
    @(negedge clk);
    i_digit_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_entry", 7'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("held_in_reset", 7'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/double_fig_merge.md
DOUBLE_FIG_MERGE -- requirements
Module: double_fig_merge

Interface
REQ-001 Parameter MAX_VAL, default 59, SHALL set the largest accepted merged value (legal 9..99).
REQ-002 Parameter TIMEOUT_CYC, default 50_000_000, SHALL set the partial-entry timeout in clk cycles; it is used only when DOUBLE_FIG_MERGE_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_digit, input, 4: decimal digit being entered, sampled when i_digit_vld=1.
REQ-006 Port i_digit_vld, input, 1: one-cycle strobe, i_digit valid this cycle.
REQ-007 Port i_clear, input, 1: abandons any partial entry.
REQ-008 Port o_double_fig, output, 7: last successfully merged value, 0..MAX_VAL.
REQ-009 Port o_vld, output, 1: one-cycle pulse, o_double_fig updated.
REQ-010 Port o_err, output, 1: one-cycle pulse, entry rejected.
REQ-011 Port o_busy, output, 1: high while a tens digit is held and the ones digit is awaited.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE (no digit held) and TENS (tens digit held).
REQ-013 In IDLE, a strobe with i_digit <= 9 and i_digit*10 <= MAX_VAL SHALL store the tens digit and move to TENS.
REQ-014 In IDLE, a strobe with i_digit > 9 or i_digit*10 > MAX_VAL SHALL pulse o_err next cycle and stay in IDLE.
REQ-015 In TENS, a strobe with ones <= 9 and tens*10+ones <= MAX_VAL SHALL register the sum into o_double_fig, pulse o_vld next cycle, and return to IDLE.
REQ-016 In TENS, a strobe with ones > 9 or sum > MAX_VAL SHALL pulse o_err next cycle, leave o_double_fig unchanged, and return to IDLE.
REQ-017 Latency SHALL be one cycle: o_vld/o_err are asserted in the cycle after the accepting strobe, never combinationally.
REQ-018 The multiply SHALL be implemented as (tens<<3)+(tens<<1)+ones in 7-bit arithmetic, with no divider or multiplier.
REQ-019 i_clear SHALL force IDLE without pulsing o_vld or o_err; when i_clear and i_digit_vld are both high, i_clear SHALL win and the digit SHALL be discarded.
REQ-020 o_busy SHALL be 1 exactly when the state is TENS.
REQ-021 o_vld and o_err SHALL never both be high in the same cycle.
REQ-022 Back-to-back strobes on consecutive cycles SHALL be accepted without loss; one digit pair per two strobes gives full throughput.

Reset
REQ-023 Asserting rst_n low SHALL immediately set state=IDLE, o_double_fig=0, o_vld=0, o_err=0, o_busy=0, and the timeout counter to 0, including mid-entry.
REQ-024 No strobe SHALL be accepted in the first cycle after rst_n deasserts if it coincides with the deassertion edge.

Configuration
REQ-025 When DOUBLE_FIG_MERGE_TIMEOUT_EN is defined:
- a counter SHALL run while in TENS and reset on every state entry;
- when the counter reaches TIMEOUT_CYC-1 without a strobe, the FSM SHALL return to IDLE and pulse o_err.
REQ-026 When DOUBLE_FIG_MERGE_TIMEOUT_EN is undefined, no counter SHALL exist and TENS SHALL be held indefinitely.

Structure
REQ-027 The state encoding (IDLE=1'b0, TENS=1'b1) and the default MAX_VAL constant SHALL live in the shared package clock_pkg.
REQ-028 Digit-range and sum-limit checking SHALL be a combinational sub-module, fig_digit_check, instantiated once; the FSM and registers stay in double_fig_merge.

Verification
REQ-029 Strobes 4 then 7, MAX_VAL=59 -> o_vld pulse one cycle after the second strobe, o_double_fig=47, o_busy high between the two strobes.
REQ-030 Strobes 6 with MAX_VAL=59 -> o_err pulse, state IDLE, o_double_fig unchanged; strobes 5 then 9 -> o_double_fig=59.
REQ-031 Strobe 3, then i_clear together with a strobe of 2 -> no o_vld or o_err, IDLE; strobes 1 then 5 -> o_double_fig=15.
REQ-032 Strobe 2, then a strobe of 12 (4'hC) -> o_err pulse, o_double_fig keeps its prior value 15, IDLE.
REQ-033 With the macro defined and TIMEOUT_CYC=8: strobe 3, then idle 8 cycles -> o_err pulse and o_busy low; rst_n pulled low in TENS -> all outputs 0 immediately.
